// File: rtl/mccu_seq.sv
// mccu_seq: multi-cycle CPU control unit FSM (IF/ID/EXE/MEM/WB) with retired-instruction counter
module mccu_seq (
    input  logic        clock,
    input  logic        resetn,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic        z,
    output logic        wpc,
    output logic        wir,
    output logic        wmem,
    output logic        wreg,
    output logic        iord,
    output logic        regrt,
    output logic        m2reg,
    output logic        shift,
    output logic        jal,
    output logic        sext,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [3:0]  aluc,
    output logic [1:0]  pcsource,
    output logic [2:0]  state,
    output logic [31:0] icount
);
    typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
    state_t cur, nxt;
    logic rtype, i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
    logic r_alu, imm_alu, branch, illegal, jump, retire;
    logic is_if, is_id, is_exe, is_mem, is_wb;
    assign rtype  = op == 6'b000000;
    assign i_add  = rtype & (func == 6'b100000);
    assign i_sub  = rtype & (func == 6'b100010);
    assign i_and  = rtype & (func == 6'b100100);
    assign i_or   = rtype & (func == 6'b100101);
    assign i_xor  = rtype & (func == 6'b100110);
    assign i_sll  = rtype & (func == 6'b000000);
    assign i_srl  = rtype & (func == 6'b000010);
    assign i_sra  = rtype & (func == 6'b000011);
    assign i_jr   = rtype & (func == 6'b001000);
    assign i_addi = op == 6'b001000;
    assign i_andi = op == 6'b001100;
    assign i_ori  = op == 6'b001101;
    assign i_xori = op == 6'b001110;
    assign i_lw   = op == 6'b100011;
    assign i_sw   = op == 6'b101011;
    assign i_beq  = op == 6'b000100;
    assign i_bne  = op == 6'b000101;
    assign i_lui  = op == 6'b001111;
    assign i_j    = op == 6'b000010;
    assign i_jal  = op == 6'b000011;
    assign r_alu   = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra;
    assign imm_alu = i_addi | i_andi | i_ori | i_xori | i_lui;
    assign branch  = i_beq | i_bne;
    assign illegal = ~(r_alu | i_jr | imm_alu | i_lw | i_sw | branch | i_j | i_jal);
    // Jumps and illegal instructions both finish in ID, so they share the early exit.
    assign jump    = i_j | i_jal | i_jr | illegal;
    assign is_if  = cur == S_IF;
    assign is_id  = cur == S_ID;
    assign is_exe = cur == S_EXE;
    assign is_mem = cur == S_MEM;
    assign is_wb  = cur == S_WB;
    assign retire = (is_id & jump) | (is_exe & branch) | (is_mem & i_sw) | is_wb;
    assign state  = cur;
    always_comb begin
        nxt = is_if  ? S_ID :
              is_id  ? (jump ? S_IF : S_EXE) :
              is_exe ? ((i_lw | i_sw) ? S_MEM : branch ? S_IF : S_WB) :
              is_mem ? (i_lw ? S_WB : S_IF) : S_IF;
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cur    <= S_IF;
            icount <= '0;
        end else begin
            cur    <= nxt;
            icount <= icount + {31'b0, retire};
        end
    end
    always_comb begin
        wpc      = is_if | (is_id & (i_j | i_jal | i_jr)) | (is_exe & ((i_beq & z) | (i_bne & ~z)));
        wir      = is_if;
        wmem     = is_mem & i_sw;
        wreg     = (is_id & i_jal) | is_wb;
        iord     = is_mem;
        regrt    = is_wb & ~rtype;
        m2reg    = is_wb & i_lw;
        shift    = is_exe & (i_sll | i_srl | i_sra);
        jal      = is_id & i_jal;
        sext     = i_addi | i_lw | i_sw | branch;
        alusrca  = is_exe;
        alusrcb  = is_if ? 2'b01 : is_id ? 2'b11 : (is_exe & ~rtype & ~branch) ? 2'b10 : 2'b00;
        aluc     = !is_exe ? 4'b0000 :
                   (branch | i_sub) ? 4'b0100 :
                   (i_and | i_andi) ? 4'b0001 :
                   (i_or  | i_ori)  ? 4'b0101 :
                   (i_xor | i_xori) ? 4'b0010 :
                   i_lui ? 4'b0110 : i_sll ? 4'b0011 : i_srl ? 4'b0111 : i_sra ? 4'b1111 : 4'b0000;
        pcsource = (is_id & (i_j | i_jal)) ? 2'b11 : (is_id & i_jr) ? 2'b10 : (is_exe & branch) ? 2'b01 : 2'b00;
    end
endmodule

// File: tb/tb_mccu_seq.sv
// tb_mccu_seq: randomized checks of mccu_seq against an instruction-level reference model
module tb_mccu_seq;
    logic        clock = 1'b0, resetn = 1'b0, z = 1'b0;
    logic [5:0]  op = '0, func = '0;
    logic        wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, jal, sext, alusrca;
    logic [1:0]  alusrcb, pcsource;
    logic [3:0]  aluc;
    logic [2:0]  state;
    logic [31:0] icount;
    logic [17:0] act;
    int n_chk = 0, n_fail = 0;
    logic [31:0] exp_cnt = '0;

    localparam int K_R = 0, K_SH = 1, K_JR = 2, K_I = 3, K_LW = 4, K_SW = 5;
    localparam int K_BEQ = 6, K_BNE = 7, K_J = 8, K_JAL = 9, K_ILL = 10;

    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        int         kind;
        logic [3:0] aluc;
        bit         sext;
    } ins_t;
    ins_t tbl[20];

    mccu_seq dut (
        .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z),
        .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt),
        .m2reg(m2reg), .shift(shift), .jal(jal), .sext(sext), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource), .state(state), .icount(icount)
    );

    always #5 clock = ~clock;
    assign act = {wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, jal, alusrca, alusrcb, aluc, pcsource};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic init_tbl();
        tbl[0]  = '{6'o00, 6'b100000, K_R,   4'b0000, 1'b0};
        tbl[1]  = '{6'o00, 6'b100010, K_R,   4'b0100, 1'b0};
        tbl[2]  = '{6'o00, 6'b100100, K_R,   4'b0001, 1'b0};
        tbl[3]  = '{6'o00, 6'b100101, K_R,   4'b0101, 1'b0};
        tbl[4]  = '{6'o00, 6'b100110, K_R,   4'b0010, 1'b0};
        tbl[5]  = '{6'o00, 6'b000000, K_SH,  4'b0011, 1'b0};
        tbl[6]  = '{6'o00, 6'b000010, K_SH,  4'b0111, 1'b0};
        tbl[7]  = '{6'o00, 6'b000011, K_SH,  4'b1111, 1'b0};
        tbl[8]  = '{6'o00, 6'b001000, K_JR,  4'b0000, 1'b0};
        tbl[9]  = '{6'b001000, 6'h00, K_I,   4'b0000, 1'b1};
        tbl[10] = '{6'b001100, 6'h00, K_I,   4'b0001, 1'b0};
        tbl[11] = '{6'b001101, 6'h00, K_I,   4'b0101, 1'b0};
        tbl[12] = '{6'b001110, 6'h00, K_I,   4'b0010, 1'b0};
        tbl[13] = '{6'b001111, 6'h00, K_I,   4'b0110, 1'b0};
        tbl[14] = '{6'b100011, 6'h00, K_LW,  4'b0000, 1'b1};
        tbl[15] = '{6'b101011, 6'h00, K_SW,  4'b0000, 1'b1};
        tbl[16] = '{6'b000100, 6'h00, K_BEQ, 4'b0100, 1'b1};
        tbl[17] = '{6'b000101, 6'h00, K_BNE, 4'b0100, 1'b1};
        tbl[18] = '{6'b000010, 6'h00, K_J,   4'b0000, 1'b0};
        tbl[19] = '{6'b000011, 6'h00, K_JAL, 4'b0000, 1'b0};
    endtask

    function automatic bit is_legal(input logic [5:0] o, input logic [5:0] f);
        for (int i = 0; i < 20; i++)
            if (tbl[i].op == o && (o != 6'd0 || tbl[i].func == f)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int latency(input int k);
        if (k == K_J || k == K_JAL || k == K_JR || k == K_ILL) return 2;
        if (k == K_BEQ || k == K_BNE) return 3;
        if (k == K_LW) return 5;
        return 4;
    endfunction

    // Expected control vector for one instruction in one state, straight from the per-state rules.
    function automatic logic [17:0] exp_out(input ins_t e, input int st, input bit zv);
        logic ewpc = 0, ewir = 0, ewmem = 0, ewreg = 0, eiord = 0, eregrt = 0, em2reg = 0;
        logic eshift = 0, ejal = 0, easa = 0;
        logic [1:0] easb = 2'b00, epcs = 2'b00;
        logic [3:0] ealuc = 4'b0000;
        bit br = (e.kind == K_BEQ || e.kind == K_BNE);
        case (st)
            0: begin ewpc = 1; ewir = 1; easb = 2'b01; end
            1: begin
                easb = 2'b11;
                if (e.kind == K_J)   begin ewpc = 1; epcs = 2'b11; end
                if (e.kind == K_JR)  begin ewpc = 1; epcs = 2'b10; end
                if (e.kind == K_JAL) begin ewpc = 1; epcs = 2'b11; ewreg = 1; ejal = 1; end
            end
            2: begin
                easa = 1;
                if (br) begin
                    ealuc = 4'b0100; epcs = 2'b01;
                    ewpc = (e.kind == K_BEQ) ? zv : ~zv;
                end else begin
                    easb = (e.kind == K_R || e.kind == K_SH) ? 2'b00 : 2'b10;
                    eshift = (e.kind == K_SH);
                    ealuc = e.aluc;
                end
            end
            3: begin eiord = 1; ewmem = (e.kind == K_SW); end
            4: begin ewreg = 1; eregrt = (e.kind == K_I || e.kind == K_LW); em2reg = (e.kind == K_LW); end
            default: ;
        endcase
        return {ewpc, ewir, ewmem, ewreg, eiord, eregrt, em2reg, eshift, ejal, easa, easb, ealuc, epcs};
    endfunction

    // Called just after a falling edge with the FSM in IF; returns just after a falling edge in IF.
    task automatic run_instr(input ins_t e, input bit zv);
        int n = latency(e.kind);
        op = e.op; func = e.func; z = zv;
        for (int k = 0; k < n; k++) begin
            int st = (k == 3 && e.kind != K_LW && e.kind != K_SW) ? 4 : k;
            #1;
            n_chk++;
            if (state !== 3'(st)) begin
                n_fail++;
                $display("FAIL state op=%b func=%b step=%0d: got %0d expected %0d", e.op, e.func, k, state, st);
            end
            n_chk++;
            if (act !== exp_out(e, st, zv)) begin
                n_fail++;
                $display("FAIL ctrl op=%b func=%b z=%b state=%0d: got %b expected %b", e.op, e.func, zv, st, act, exp_out(e, st, zv));
            end
            if (st == 1 || st == 2) begin
                n_chk++;
                if (sext !== e.sext) begin
                    n_fail++;
                    $display("FAIL sext op=%b func=%b: got %b expected %b", e.op, e.func, sext, e.sext);
                end
            end
            @(negedge clock);
        end
        exp_cnt = exp_cnt + 32'd1;
        #1;
        n_chk++;
        if (state !== 3'd0 || icount !== exp_cnt) begin
            n_fail++;
            $display("FAIL retire op=%b func=%b: state=%0d icount=%h expected state=0 icount=%h", e.op, e.func, state, icount, exp_cnt);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        n_chk++;
        if (state !== 3'd0 || icount !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d icount=%h expected 0/0", state, icount);
        end
        n_chk++;
        if (act !== 18'b11_0000_0000_01_0000_00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected IF controls", act);
        end
        exp_cnt = '0;
        resetn = 1'b1;
    endtask

    task automatic test_each_instr();
        for (int i = 0; i < 20; i++) run_instr(tbl[i], 1'($urandom));
    endtask

    task automatic test_branches();
        run_instr(tbl[16], 1'b1);
        run_instr(tbl[16], 1'b0);
        run_instr(tbl[17], 1'b1);
        run_instr(tbl[17], 1'b0);
    endtask

    task automatic test_illegal();
        ins_t e = '{6'b111111, 6'h00, K_ILL, 4'b0000, 1'b0};
        run_instr(e, 1'b0);
        e.op = 6'd0; e.func = 6'b000001;
        run_instr(e, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            ins_t e;
            if ($urandom_range(0, 7) == 0) begin
                logic [5:0] o, f;
                do begin o = 6'($urandom); f = 6'($urandom); end while (is_legal(o, f));
                e = '{o, f, K_ILL, 4'b0000, 1'b0};
            end else e = tbl[$urandom_range(0, 19)];
            run_instr(e, 1'($urandom));
        end
    endtask

    task automatic test_reset_mid_sw();
        op = tbl[15].op; func = tbl[15].func; z = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        n_chk++;
        if (state !== 3'd3 || wmem !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_mem_before_reset: state=%0d wmem=%b expected 3/1", state, wmem);
        end
        #1 resetn = 1'b0;
        #1;
        n_chk++;
        if (state !== 3'd0 || wmem !== 1'b0 || icount !== 32'd0) begin
            n_fail++;
            $display("FAIL async_abort: state=%0d wmem=%b icount=%h expected 0/0/0", state, wmem, icount);
        end
        @(posedge clock);
        #1;
        n_chk++;
        if (state !== 3'd0 || wmem !== 1'b0 || wreg !== 1'b0) begin
            n_fail++;
            $display("FAIL held_in_reset: state=%0d wmem=%b wreg=%b expected 0/0/0", state, wmem, wreg);
        end
        @(negedge clock);
        exp_cnt = '0;
        resetn = 1'b1;
        run_instr(tbl[14], 1'b0);
    endtask

    task automatic test_wrap();
        dut.icount = 32'hFFFF_FFFF;
        exp_cnt = 32'hFFFF_FFFF;
        run_instr(tbl[18], 1'b0);
        n_chk++;
        if (icount !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap: icount=%h expected 00000000", icount);
        end
    endtask

    initial begin
        init_tbl();
        test_reset();
        test_each_instr();
        test_branches();
        test_illegal();
        test_random();
        test_reset_mid_sw();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
